instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/core_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/instruction_fetch.sv | 84 ++++++++
 tb/tb_instruction_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the fetch front end.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} fetch buffer with push/pop/flush; flush wins over both.
module fetch_fifo
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    // A push into a full buffer is only accepted when the head leaves the same cycle.
    do_push  = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // NOTE: the storage is reset (it is only two entries) so the head outputs read
  // zero during reset instead of X; larger RAM-style buffers would not be reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencing, redirect handling and flow control into a
// two-entry buffer in front of a registered instruction memory.
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] fetch_pc;
  logic [2:0]      occupancy;
  logic            issue, pop, push;
  fetch_entry_t    push_entry, head;
  logic            fifo_empty, unused_fifo_full;
  logic [1:0]      fifo_count;

  assign pop        = if_valid && if_ready;
  assign push       = inflight_q && !redirect_valid;
  assign push_entry = '{pc: req_pc_q, instr: imem_instr};
  assign fetch_pc   = redirect_valid ? (redirect_pc & ~32'h3) : pc_q;
  assign imem_addr  = {2'b00, fetch_pc[XLEN-1:2]};

  // Only issue when the buffer is guaranteed a slot for the response one cycle later.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = redirect_valid || (occupancy < 3'(FIFO_DEPTH));

  // NOTE: next-state is computed combinationally with blocking assignments and
  // defaults first, so every path assigns every signal and no latch is inferred.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    if (issue) begin
      pc_d       = fetch_pc + 32'd4;
      req_pc_d   = fetch_pc;
      inflight_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign if_valid = !fifo_empty;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch against a registered memory model.
module tb_instruction_fetch;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int           tests_run = 0;
  int           tests_failed = 0;
  fetch_entry_t sb [$];
  logic         seen_200 = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always @(posedge clk) imem_instr <= 32'h1000_0000 + imem_addr;

  function automatic fetch_entry_t mk(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = 32'h1000_0000 + (pc >> 2);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted head outside a redirect cycle must match the queue head.
  always @(negedge clk) begin
    if (rst && if_valid && if_ready && !redirect_valid) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected nothing", if_pc, if_instr);
      end else begin
        fetch_entry_t e;
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          tests_failed++;
          $display("FAIL sb_accept: got pc=%h instr=%h, expected pc=%h instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
    if (rst && if_valid && if_pc == 32'h200) seen_200 = 1'b1;
  end

  always @(negedge clk) begin
    if (rst && u_dut.push && u_dut.u_fifo.full && !u_dut.pop) begin
      tests_failed++;
      $display("FAIL push_full: push into full buffer at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    sb.delete();
    tick();
    tick();
  endtask

  task automatic run_stream();
    if_ready = 1'b1;
    sb.push_back(mk(32'h0));
    sb.push_back(mk(32'h4));
    sb.push_back(mk(32'h8));
    rst = 1'b1;
    tick();
    tests_run++;
    if (if_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stream_edge1_valid: got %b expected 0", if_valid);
    end
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin
      tests_failed++;
      $display("FAIL stream_first: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=10000000", if_valid, if_pc, if_instr);
    end
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h1000_0001) begin
      tests_failed++;
      $display("FAIL stream_second: got v=%b pc=%h instr=%h expected v=1 pc=4 instr=10000001", if_valid, if_pc, if_instr);
    end
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h1000_0002) begin
      tests_failed++;
      $display("FAIL stream_third: got v=%b pc=%h instr=%h expected v=1 pc=8 instr=10000002", if_valid, if_pc, if_instr);
    end
    tick();
    if_ready = 1'b0;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL stream_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    tests_run++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b pc=%h instr=%h addr=%h expected all 0", if_valid, if_pc, if_instr, imem_addr);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    run_stream();
  endtask

  task automatic test_stall();
    apply_reset();
    sb.push_back(mk(32'h0));
    sb.push_back(mk(32'h4));
    sb.push_back(mk(32'h8));
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=10000000", i, if_valid, if_pc, if_instr);
      end
    end
    tests_run++;
    if (u_dut.u_fifo.count !== 2'd2 || u_dut.inflight_q !== 1'b0 || imem_addr !== 32'h2) begin
      tests_failed++;
      $display("FAIL stall_full: got count=%0d inflight=%b addr=%h expected 2 0 00000002", u_dut.u_fifo.count, u_dut.inflight_q, imem_addr);
    end
    if_ready = 1'b1;
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
      tests_failed++; $display("FAIL stall_release_4: got v=%b pc=%h expected v=1 pc=4", if_valid, if_pc);
    end
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
      tests_failed++; $display("FAIL stall_release_8: got v=%b pc=%h expected v=1 pc=8", if_valid, if_pc);
    end
    tick();
    if_ready = 1'b0;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL stall_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_redirect_full();
    tick();
    tick();
    tests_run++;
    if (u_dut.u_fifo.count !== 2'd2) begin
      tests_failed++; $display("FAIL redir_precond_full: got count=%0d expected 2", u_dut.u_fifo.count);
    end
    sb.delete();
    sb.push_back(mk(32'h100));
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    if_ready = 1'b1;
    #1;
    tests_run++;
    if (imem_addr !== 32'h40) begin
      tests_failed++; $display("FAIL redir_addr: got %h expected 00000040", imem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (if_valid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_flushed: got v=%b pc=%h expected v=0", if_valid, if_pc);
    end
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h1000_0040) begin
      tests_failed++;
      $display("FAIL redir_target: got v=%b pc=%h instr=%h expected v=1 pc=100 instr=10000040", if_valid, if_pc, if_instr);
    end
    tick();
    if_ready = 1'b0;
    tests_run++;
    if (if_pc !== 32'h104 || sb.size() != 0) begin
      tests_failed++; $display("FAIL redir_next: got pc=%h pending=%0d expected pc=104 pending=0", if_pc, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    sb.delete();
    sb.push_back(mk(32'h300));
    sb.push_back(mk(32'h304));
    seen_200 = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tests_run++;
    if (if_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_flush1: got v=%b expected 0", if_valid);
    end
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (if_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_flush2: got v=%b pc=%h expected v=0", if_valid, if_pc);
    end
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== 32'h1000_00C0) begin
      tests_failed++;
      $display("FAIL b2b_target: got v=%b pc=%h instr=%h expected v=1 pc=300 instr=100000c0", if_valid, if_pc, if_instr);
    end
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h304) begin
      tests_failed++; $display("FAIL b2b_next: got v=%b pc=%h expected v=1 pc=304", if_valid, if_pc);
    end
    tick();
    if_ready = 1'b0;
    tests_run++;
    if (seen_200 !== 1'b0 || sb.size() != 0) begin
      tests_failed++; $display("FAIL b2b_no_200: got seen=%b pending=%0d expected 0 0", seen_200, sb.size());
    end
  endtask

  task automatic test_wrap();
    sb.delete();
    sb.push_back(mk(32'hFFFF_FFFC));
    sb.push_back(mk(32'h0));
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h4FFF_FFFF) begin
      tests_failed++;
      $display("FAIL wrap_top: got v=%b pc=%h instr=%h expected v=1 pc=fffffffc instr=4fffffff", if_valid, if_pc, if_instr);
    end
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) begin
      tests_failed++;
      $display("FAIL wrap_zero: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=10000000", if_valid, if_pc, if_instr);
    end
    tick();
    if_ready = 1'b0;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL wrap_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset_midop();
    tick();
    tick();
    tick();
    tests_run++;
    if (u_dut.u_fifo.count !== 2'd2) begin
      tests_failed++; $display("FAIL midrst_precond: got count=%0d expected 2", u_dut.u_fifo.count);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (if_valid !== 1'b0 || u_dut.u_fifo.count !== 2'd0 || u_dut.inflight_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_drop: got v=%b count=%0d inflight=%b expected 0 0 0", if_valid, u_dut.u_fifo.count, u_dut.inflight_q);
    end
    sb.delete();
    tick();
    tick();
    run_stream();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_back_to_back();
    test_wrap();
    test_reset_midop();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
